// File: rtl/regfile_pkg.sv
// Shared register-file constants and index type used by the write-side demux.
package regfile_pkg;

    localparam int NREGS_DEF  = 32;
    localparam int WIDTH_DEF  = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_IDX   = 31;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage : regfile_pkg

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder; output is all-zero when en is low.
module decoder_onehot #(
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [N-1:0]      onehot
);

    // Select a single line for the requested index when enabled.
    always_comb begin
        onehot = {N{1'b0}};
        if (en) begin
            onehot[addr] = 1'b1;
        end else begin
            onehot = {N{1'b0}};
        end
    end

endmodule : decoder_onehot

// File: rtl/reg_demux.sv
// Register-file write port: 1:NREGS demux with a capture/decode stage and a commit stage.
module reg_demux
    import regfile_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int ADDR_W  = $clog2(NREGS),
    parameter int ZERO_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [NREGS*WIDTH-1:0] q,
    output logic                   wr_done,
    output logic                   busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    logic             zero_hit_s;
    logic [NREGS-1:0] dec_onehot_s;

    logic             s1_valid_d,  s1_valid_q;
    logic [NREGS-1:0] s1_onehot_d, s1_onehot_q;
    logic [WIDTH-1:0] s1_data_d,   s1_data_q;
    logic             wr_done_d,   wr_done_q;

    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] regs_q [NREGS];

    // Writes to the hardwired-zero register decode to no destination at all.
    assign zero_hit_s = (ZERO_EN != 0) && (wr_addr == LAST_IDX);

    decoder_onehot #(
        .N      (NREGS),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en     (wr_en && !zero_hit_s),
        .addr   (wr_addr),
        .onehot (dec_onehot_s)
    );

    // Capture stage next-state.
    always_comb begin
        s1_valid_d  = wr_en;
        s1_onehot_d = dec_onehot_s;
        s1_data_d   = wr_data;
    end

    // Capture stage registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_onehot_q <= {NREGS{1'b0}};
            s1_data_q   <= {WIDTH{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_onehot_q <= s1_onehot_d;
            s1_data_q   <= s1_data_d;
        end
    end

    // Completion pulse only when a real register is updated.
    always_comb begin
        wr_done_d = s1_valid_q && (|s1_onehot_q);
    end

    // Completion flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= wr_done_d;
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        // Commit the captured word only into the selected register.
        always_comb begin
            if (s1_valid_q && s1_onehot_q[k]) begin
                regs_d[k] = s1_data_q;
            end else begin
                regs_d[k] = regs_q[k];
            end
        end

        // Destination register storage.
        always_ff @(posedge clk) begin
            if (reset) begin
                regs_q[k] <= {WIDTH{1'b0}};
            end else begin
                regs_q[k] <= regs_d[k];
            end
        end

        assign q[k*WIDTH +: WIDTH] = regs_q[k];
    end

    assign wr_done = wr_done_q;
    assign busy    = s1_valid_q;

endmodule : reg_demux

// File: tb/tb_reg_demux.sv
// Randomized and directed bench for reg_demux against a transaction-level register-file model.
module tb_reg_demux;

    localparam int W = 64;
    localparam int N = 32;
    localparam int A = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [W-1:0]   wr_data;
    logic [N*W-1:0] q_z, q_n;
    logic           done_z, done_n, busy_z, busy_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: committed contents of each instance plus the single write in flight.
    logic [W-1:0] exp_z [N];
    logic [W-1:0] exp_n [N];
    logic         exp_done_z, exp_done_n;
    logic         p_valid;
    logic [A-1:0] p_addr;
    logic [W-1:0] p_data;

    always #5 clk = ~clk;

    reg_demux #(.WIDTH(W), .NREGS(N), .ADDR_W(A), .ZERO_EN(1)) dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .q(q_z), .wr_done(done_z), .busy(busy_z)
    );

    reg_demux #(.WIDTH(W), .NREGS(N), .ADDR_W(A), .ZERO_EN(0)) dut_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .q(q_n), .wr_done(done_n), .busy(busy_n)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, then compare.
    task automatic step(input logic en, input logic [A-1:0] a, input logic [W-1:0] d, input logic rst);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        reset   = rst;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                exp_z[k] = '0;
                exp_n[k] = '0;
            end
            p_valid    = 1'b0;
            exp_done_z = 1'b0;
            exp_done_n = 1'b0;
        end else begin
            exp_done_n = p_valid;
            exp_done_z = p_valid && (p_addr != 5'd31);
            if (p_valid) begin
                exp_n[p_addr] = p_data;
                if (p_addr != 5'd31) exp_z[p_addr] = p_data;
            end
            p_valid = en;
            p_addr  = a;
            p_data  = d;
        end
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("z_reg%0d", k), q_z[k*W +: W], exp_z[k]);
            check($sformatf("n_reg%0d", k), q_n[k*W +: W], exp_n[k]);
        end
        check("z_wr_done", 64'(done_z), 64'(exp_done_z));
        check("n_wr_done", 64'(done_n), 64'(exp_done_n));
        check("z_busy", 64'(busy_z), 64'(p_valid));
        check("n_busy", 64'(busy_n), 64'(p_valid));
        check("z_onehot0", 64'($onehot0(dut_z.s1_onehot_q)), 64'd1);
        check("n_onehot0", 64'($onehot0(dut_n.s1_onehot_q)), 64'd1);
    endtask

    initial begin
        p_valid = 1'b0;
        p_addr  = '0;
        p_data  = '0;

        step(1'b0, 5'd0, 64'd0, 1'b1);
        step(1'b1, 5'd4, 64'd99, 1'b1);
        repeat (3) step(1'b0, 5'd0, 64'd0, 1'b0);

        step(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0004, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);

        step(1'b1, 5'd3, 64'd4, 1'b0);
        step(1'b1, 5'd3, 64'd64, 1'b0);
        step(1'b1, 5'd7, 64'd1, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);

        step(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);

        step(1'b1, 5'd9, 64'd123, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b0);

        for (int k = 0; k < N; k++) step(1'b1, A'(k), 64'(k + 1), 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), A'($urandom_range(0, N - 1)),
                 {$urandom, $urandom}, ($urandom_range(0, 39) == 0));
        end
        step(1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_demux
